// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined IEEE-754 multiplier.
// Stage 1 decodes the operands, stage 2 multiplies the significands, and
// stage 3 normalises, rounds and packs. The default build is binary32.
// All five RISC-V rounding modes, subnormals, canonical NaN and fflags.
module fmul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  input  logic [2:0]              rm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   z,
  output logic [4:0]              fflags
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * MW;
  localparam int SW = EXP_W + 2;
  // Wide enough for the exponent sum minus a full-width leading-zero count.
  localparam int XW = EXP_W + 9;
  localparam logic [SW-1:0]        BIAS = SW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EXP_W-1:0]     EMAX = '1;
  localparam logic [W-1:0]         QNAN = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] PWX  = XW'(PW);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Increment decision for a magnitude given its LSB, guard and sticky.
  function automatic logic round_inc(input logic [2:0] mode, input logic s,
                                     input logic lsb, input logic g, input logic st);
    case (mode)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return s & (g | st);
      RM_RUP:  return ~s & (g | st);
      RM_RMM:  return g;
      default: return g & (st | lsb);
    endcase
  endfunction

  // Overflow saturates to infinity only when the mode rounds away from zero.
  function automatic logic ovf_to_inf(input logic [2:0] mode, input logic s);
    case (mode)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return s;
      RM_RUP:  return ~s;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] lzc(input logic [PW-1:0] v);
    logic [7:0] n;
    n = 8'(PW);
    for (int i = 0; i < PW; i++)
      if (v[i]) n = 8'(PW - 1 - i);
    return n;
  endfunction

  logic adv;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  // ---------------- stage 1: decode ----------------
  logic [EXP_W-1:0]  ea_f, eb_f;
  logic [FRAC_W-1:0] fa, fb;
  logic a_zero, b_zero, a_sub, b_sub, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [MW-1:0]     ma, mb;
  logic [SW-1:0]     ea_eff, eb_eff;
  logic signed [SW-1:0] esum;
  logic              sign, spec, spec_nv;
  logic [W-1:0]      spec_z;
  logic [2:0]        rm_n;

  assign ea_f   = a[W-2:FRAC_W];
  assign eb_f   = b[W-2:FRAC_W];
  assign fa     = a[FRAC_W-1:0];
  assign fb     = b[FRAC_W-1:0];
  assign a_zero = (ea_f == '0) && (fa == '0);
  assign b_zero = (eb_f == '0) && (fb == '0);
  assign a_sub  = (ea_f == '0) && (fa != '0);
  assign b_sub  = (eb_f == '0) && (fb != '0);
  assign a_inf  = (ea_f == EMAX) && (fa == '0);
  assign b_inf  = (eb_f == EMAX) && (fb == '0);
  assign a_nan  = (ea_f == EMAX) && (fa != '0);
  assign b_nan  = (eb_f == EMAX) && (fb != '0);
  assign a_snan = a_nan & ~fa[FRAC_W-1];
  assign b_snan = b_nan & ~fb[FRAC_W-1];
  assign ma     = {|ea_f, fa};
  assign mb     = {|eb_f, fb};
  assign ea_eff = a_sub ? SW'(1) : {2'b00, ea_f};
  assign eb_eff = b_sub ? SW'(1) : {2'b00, eb_f};
  assign esum   = $signed(ea_eff) + $signed(eb_eff) - $signed(BIAS);
  assign sign   = a[W-1] ^ b[W-1];
  assign rm_n   = (rm > RM_RMM) ? RM_RNE : rm;

  // Special operands bypass the arithmetic with a precomputed result.
  always_comb begin
    spec    = 1'b0;
    spec_nv = 1'b0;
    spec_z  = '0;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      spec    = 1'b1;
      spec_z  = QNAN;
      spec_nv = a_snan | b_snan | (a_inf & b_zero) | (b_inf & a_zero);
    end else if (a_inf | b_inf) begin
      spec   = 1'b1;
      spec_z = {sign, EMAX, {FRAC_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      spec   = 1'b1;
      spec_z = {sign, {(W-1){1'b0}}};
    end
  end

  logic                 sign_p1, spec_p1, spec_nv_p1;
  logic signed [SW-1:0] esum_p1;
  logic [MW-1:0]        ma_p1, mb_p1;
  logic [2:0]           rm_p1;
  logic [W-1:0]         spec_z_p1;

  // ---------------- stage 2: multiply ----------------
  logic                 sign_p2, spec_p2, spec_nv_p2;
  logic signed [SW-1:0] esum_p2;
  logic [PW-1:0]        prod_p2;
  logic [2:0]           rm_p2;
  logic [W-1:0]         spec_z_p2;

  // Datapath registers: advance with the pipe, no reset needed.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1    <= sign;
      spec_p1    <= spec;
      spec_nv_p1 <= spec_nv;
      spec_z_p1  <= spec_z;
      esum_p1    <= esum;
      ma_p1      <= ma;
      mb_p1      <= mb;
      rm_p1      <= rm_n;
      sign_p2    <= sign_p1;
      spec_p2    <= spec_p1;
      spec_nv_p2 <= spec_nv_p1;
      spec_z_p2  <= spec_z_p1;
      esum_p2    <= esum_p1;
      prod_p2    <= ma_p1 * mb_p1;
      rm_p2      <= rm_p1;
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [7:0]            lz;
  logic [PW-1:0]         norm;
  logic signed [XW-1:0]  exp_n, shv;
  logic                  sub;
  logic [XW-1:0]         sh, exp_f, rexp;
  logic [2*PW-1:0]       wide;
  logic [PW-1:0]         den;
  logic [MW-1:0]         keep;
  logic                  g, st, inc, inexact, ovf, tiny;
  logic [XW+FRAC_W-1:0]  rsum;
  logic [W-1:0]          z_n;
  logic [4:0]            fl_n;

  assign lz    = lzc(prod_p2);
  assign norm  = prod_p2 << lz;
  assign exp_n = {{(XW-SW){esum_p2[SW-1]}}, esum_p2} + ONE - {{(XW-8){1'b0}}, lz};
  assign sub   = exp_n < ONE;
  assign shv   = ONE - exp_n;
  assign sh    = sub ? ((shv > PWX) ? PWX : shv) : '0;
  assign wide  = {norm, {PW{1'b0}}} >> sh;
  assign den   = wide[2*PW-1:PW];
  assign keep  = den[PW-1 -: MW];
  assign g     = den[PW-MW-1];
  assign st    = (|den[PW-MW-2:0]) | (|wide[PW-1:0]);
  assign exp_f = sub ? '0 : exp_n;
  assign inc   = round_inc(rm_p2, sign_p2, keep[0], g, st);
  // The carry out of the fraction ripples into the exponent, covering both
  // mantissa overflow and a subnormal rounding up to the minimum normal.
  assign rsum  = {exp_f, keep[FRAC_W-1:0]} + (XW+FRAC_W)'(inc);
  assign rexp  = rsum[XW+FRAC_W-1:FRAC_W];
  assign ovf   = rexp >= {{(XW-EXP_W){1'b0}}, EMAX};
  assign inexact = g | st;
  // Tiny after rounding: only a value just below 2^emin whose unbounded
  // rounding carries up to 2^emin escapes being tiny.
  assign tiny  = sub & ~((exp_n == '0) & (&norm[PW-1 -: MW]) &
                 round_inc(rm_p2, sign_p2, 1'b1, norm[PW-MW-1], |norm[PW-MW-2:0]));

  // Select special, overflow or ordinary rounded result and its flags.
  always_comb begin
    z_n  = '0;
    fl_n = '0;
    if (spec_p2) begin
      z_n  = spec_z_p2;
      fl_n = {spec_nv_p2, 4'b0000};
    end else if (ovf) begin
      z_n  = ovf_to_inf(rm_p2, sign_p2) ? {sign_p2, EMAX, {FRAC_W{1'b0}}}
                                        : {sign_p2, EMAX - 1'b1, {FRAC_W{1'b1}}};
      fl_n = 5'b00101;
    end else begin
      z_n  = {sign_p2, rexp[EXP_W-1:0], rsum[FRAC_W-1:0]};
      fl_n = {3'b000, tiny & inexact, inexact};
    end
  end

  logic             vld_p1, vld_p2, vld_p3;
  logic [W-1:0]     z_p3;
  logic [4:0]       fflags_p3;

  // Valid bits and output registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      z_p3      <= '0;
      fflags_p3 <= '0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      z_p3      <= z_n;
      fflags_p3 <= fl_n;
    end
  end

  assign out_valid = vld_p3;
  assign z         = z_p3;
  assign fflags    = fflags_p3;
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: binary32 bench for fmul_pipe with a real-arithmetic
// reference model, a result scoreboard and directed corner cases.
module tb_fmul_pipe;
  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic [2:0]  rm;
  logic [4:0]  fflags;

  fmul_pipe dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .fflags(fflags)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [36:0] sbq[$];
  logic        got_out;
  logic [31:0] last_z;
  logic [4:0]  last_fl;
  int          pop_cnt;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_z;
  logic [4:0]  prev_fl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, expv);
    end
  endtask

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real fmag(input logic [31:0] x);
    longint sig;
    int     ee;
    sig = (x[30:23] == 8'd0) ? longint'(x[22:0]) : (longint'(x[22:0]) + 64'd8388608);
    ee  = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    return real'(sig) * pow2(ee - 150);
  endfunction

  function automatic logic rnd_up(input logic [2:0] mode, input logic s, input real fr, input longint n);
    case (mode)
      3'd1:    return 1'b0;
      3'd2:    return s && (fr > 0.0);
      3'd3:    return !s && (fr > 0.0);
      3'd4:    return fr >= 0.5;
      default: return (fr > 0.5) || ((fr == 0.5) && n[0]);
    endcase
  endfunction

  // Reference: exact product in double precision, then rounded to binary32.
  task automatic ref_fmul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] mode,
                          output logic [31:0] rz, output logic [4:0] rf);
    logic   s, xn, yn, xs, ys, xi, yi, x0, y0, up, tiny, inexact, to_inf;
    real    mag, m, q, n, fr, r;
    int     e, eq;
    longint nl;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xs = xn && !x[22];
    ys = yn && !y[22];
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    x0 = (x[30:0] == 0);
    y0 = (y[30:0] == 0);
    rf = 5'b0;
    if (xn || yn || (xi && y0) || (yi && x0)) begin
      rz = 32'h7FC00000;
      rf = {(xs || ys || (xi && y0) || (yi && x0)), 4'b0};
    end else if (xi || yi) begin
      rz = {s, 8'hFF, 23'd0};
    end else if (x0 || y0) begin
      rz = {s, 31'd0};
    end else begin
      mag = fmag(x) * fmag(y);
      m = mag; e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      eq = (e < -126) ? -126 : e;
      q  = pow2(eq - 23);
      n  = mag / q; fr = n - $floor(n); nl = longint'($floor(n));
      up = rnd_up(mode, s, fr, nl);
      r  = real'(nl + longint'(up)) * q;
      inexact = (fr != 0.0);
      q  = pow2(e - 23);
      n  = mag / q; fr = n - $floor(n); nl = longint'($floor(n));
      up = rnd_up(mode, s, fr, nl);
      tiny = (real'(nl + longint'(up)) * q) < pow2(-126);
      if (r >= pow2(128)) begin
        to_inf = (mode == 3'd3) ? !s : (mode == 3'd2) ? s : (mode != 3'd1);
        rz = to_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
        rf = 5'b00101;
      end else begin
        if (r < pow2(-126)) begin
          nl = longint'(r / pow2(-149));
          rz = {s, 8'd0, nl[22:0]};
        end else begin
          m = r; e = 0;
          while (m >= 2.0) begin m = m / 2.0; e++; end
          while (m < 1.0) begin m = m * 2.0; e--; end
          nl = longint'((m - 1.0) * pow2(23));
          rz = {s, 8'(e + 127), nl[22:0]};
        end
        rf = {3'b000, tiny && inexact, inexact};
      end
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       begin e = 8'd0; f = 23'd0; end
      1:       e = 8'd0;
      2:       begin e = 8'hFF; f = 23'd0; end
      3:       begin e = 8'hFF; if (f == 0) f = 23'd1; end
      4:       e = 8'($urandom_range(200, 254));
      5:       e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  // One clock: drive at the falling edge, then settle and account.
  task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [2:0] irm, input logic ordy, output logic acc);
    logic [36:0] e;
    logic [31:0] mz;
    logic [4:0]  mf;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; rm = irm; out_ready = ordy;
    #1;
    if (prev_hold) begin
      chk("hold_z", z, prev_z);
      chk("hold_fflags", fflags, prev_fl);
    end
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", out_valid, 0);
      else begin
        e = sbq.pop_front();
        chk("z", z, e[36:5]);
        chk("fflags", fflags, e[4:0]);
      end
      got_out = 1'b1; last_z = z; last_fl = fflags; pop_cnt++;
    end
    prev_hold = out_valid && !out_ready;
    prev_z = z; prev_fl = fflags;
    acc = in_valid && in_ready;
    if (acc) begin
      ref_fmul(ia, ib, irm, mz, mf);
      sbq.push_back({mz, mf});
    end
  endtask

  task automatic directed(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] irm,
                          input logic [31:0] ez, input logic [4:0] ef);
    logic acc;
    got_out = 1'b0;
    cycle(1'b1, ia, ib, irm, 1'b1, acc);
    chk("dir_accept", acc, 1);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, acc);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, acc);
    chk("dir_early", got_out, 0);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, acc);
    chk("dir_latency", got_out, 1);
    chk("dir_z", last_z, ez);
    chk("dir_fflags", last_fl, ef);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        acc, saw_low;
    logic [31:0] oa, ob;
    logic [2:0]  orm;
    int          issued, c;
    clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; rm = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_z", z, 0);
    chk("rst_fflags", fflags, 0);
    clrn = 1'b1;

    directed(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000);
    directed(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000);
    directed(32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000);
    directed(32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000);
    directed(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b00101);
    directed(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b00101);
    directed(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b00101);
    directed(32'h00800000, 32'h3F000000, 3'd0, 32'h00400000, 5'b00000);
    directed(32'h00000001, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011);
    directed(32'h00000001, 32'h3F000000, 3'd3, 32'h00000001, 5'b00011);
    directed(32'h3F800001, 32'h3F800001, 3'd7, 32'h3F800002, 5'b00001);

    // Five back-to-back operations with the consumer stalled for six cycles.
    pop_cnt = 0; issued = 0; saw_low = 1'b0;
    oa = rand_op(); ob = rand_op(); orm = 3'($urandom_range(0, 4));
    for (c = 0; c < 30 && (issued < 5 || sbq.size() > 0); c++) begin
      cycle(issued < 5, oa, ob, orm, !(c >= 3 && c <= 8), acc);
      if (!in_ready) saw_low = 1'b1;
      if (acc) begin
        issued++;
        oa = rand_op(); ob = rand_op(); orm = 3'($urandom_range(0, 4));
      end
    end
    chk("bp_in_ready_low", saw_low, 1);
    chk("bp_results", pop_cnt, 5);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h40000000, 32'h40400000, 3'd0, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0; clrn = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    sbq.delete(); prev_hold = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    #1;
    chk("postrst_out_valid", out_valid, 0);
    directed(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000);

    // Randomised stream with random input gaps and output stalls.
    issued = 0;
    oa = rand_op(); ob = rand_op(); orm = 3'($urandom_range(0, 7));
    for (c = 0; c < 4000 && issued < 400; c++) begin
      cycle($urandom_range(0, 9) < 8, oa, ob, orm, $urandom_range(0, 9) < 7, acc);
      if (acc) begin
        issued++;
        oa = rand_op(); ob = rand_op(); orm = 3'($urandom_range(0, 7));
      end
    end
    for (c = 0; c < 40 && sbq.size() > 0; c++)
      cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, acc);
    chk("drain_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
